// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Shares one synchronous sprite ROM between the VGA display fetcher and the
//   game-logic reader. One grant per cycle; the winner's address is registered
//   onto rom_address and an owner tag follows it through two pipeline stages so
//   that rd_data (rom_q) is qualified to the right requester two cycles after
//   the request was sampled.
//   Display wins during active video (blank=1), logic wins during blanking.
//   A starvation counter forces a logic grant after MAX_WAIT denied cycles.
//
// Ports
//   vga_clk      clock (rising edge)
//   Reset        synchronous active-high reset
//   blank        1 = active display region, 0 = blanking interval
//   disp_req     single-cycle display fetch request, disp_addr its address
//   logic_req    level logic read request (held until logic_gnt), logic_addr
//   rom_q        ROM read data, one cycle after rom_address
//   rom_address  registered ROM address
//   logic_gnt    one-cycle pulse, logic request accepted
//   disp_valid   rd_data belongs to the display port
//   logic_valid  rd_data belongs to the logic port
//   rd_data      read data (zero when neither valid is set)
//   disp_miss    one-cycle pulse, a display request was dropped
//   miss_count   saturating count of dropped display requests
module sprite_rom_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 4,
  parameter int MAX_WAIT = 16
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic              blank,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              logic_req,
  input  logic [ADDR_W-1:0] logic_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [ADDR_W-1:0] rom_address,
  output logic              logic_gnt,
  output logic              disp_valid,
  output logic              logic_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              disp_miss,
  output logic [15:0]       miss_count
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_DISP  = 2'd1,
    OWN_LOGIC = 2'd2
  } owner_e;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic              eff_req;
  logic              logic_denied;
  owner_e            owner_d;
  owner_e            tag_p0;
  owner_e            tag_p1;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wait_cnt_d;
  logic [7:0]        wait_cnt_q;
  logic              force_d;
  logic              force_q;
  logic              gnt_q;
  logic              miss_d;
  logic              miss_q;
  logic [15:0]       miss_count_d;
  logic [15:0]       miss_count_q;

  // Decision stage: arbitrate on the inputs sampled at this edge.
  always_comb begin
    // A request already granted last cycle is not re-granted back to back.
    eff_req = logic_req & ~gnt_q;

    owner_d = OWN_NONE;
    if (eff_req && force_q) begin
      owner_d = OWN_LOGIC;
    end else if (eff_req && disp_req) begin
      owner_d = blank ? OWN_DISP : OWN_LOGIC;
    end else if (disp_req) begin
      owner_d = OWN_DISP;
    end else if (eff_req) begin
      owner_d = OWN_LOGIC;
    end

    logic_denied = eff_req && (owner_d != OWN_LOGIC);

    wait_cnt_d = wait_cnt_q;
    if (!logic_req || owner_d == OWN_LOGIC) begin
      wait_cnt_d = 8'd0;
    end else if (logic_denied) begin
      wait_cnt_d = sat_inc8(wait_cnt_q);
    end

    // Reaching the last allowed wait while still denied arms a forced grant
    // for the following decision.
    force_d = logic_denied && (wait_cnt_q == WAIT_LAST);

    addr_d = addr_q;
    if (owner_d == OWN_DISP) begin
      addr_d = disp_addr;
    end else if (owner_d == OWN_LOGIC) begin
      addr_d = logic_addr;
    end

    miss_d       = disp_req && (owner_d != OWN_DISP);
    miss_count_d = miss_d ? sat_inc16(miss_count_q) : miss_count_q;
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      addr_q       <= '0;
      gnt_q        <= 1'b0;
      miss_q       <= 1'b0;
      miss_count_q <= 16'd0;
      wait_cnt_q   <= 8'd0;
      force_q      <= 1'b0;
      tag_p0       <= OWN_NONE;
      tag_p1       <= OWN_NONE;
    end else begin
      // Stage p0: address presented to the ROM, tag follows it.
      addr_q       <= addr_d;
      gnt_q        <= (owner_d == OWN_LOGIC);
      miss_q       <= miss_d;
      miss_count_q <= miss_count_d;
      wait_cnt_q   <= wait_cnt_d;
      force_q      <= force_d;
      tag_p0       <= owner_d;
      // Stage p1: ROM data returns, tag qualifies it.
      tag_p1       <= tag_p0;
    end
  end

  assign rom_address = addr_q;
  assign logic_gnt   = gnt_q;
  assign disp_miss   = miss_q;
  assign miss_count  = miss_count_q;
  assign disp_valid  = (tag_p1 == OWN_DISP);
  assign logic_valid = (tag_p1 == OWN_LOGIC);
  assign rd_data     = (tag_p1 != OWN_NONE) ? rom_q : '0;

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  ADDR_W, 19, ROM word-address width.
  DATA_W, 4, ROM data (palette index) width.
  MAX_WAIT, 16, max consecutive denied cycles for the logic port before a forced grant; legal range 2..255.
REQ-002 vga_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 blank  in  1  1 = active display region, 0 = blanking interval.
REQ-005 disp_req  in  1  display fetch request; single-cycle, never held.
REQ-006 disp_addr  in  ADDR_W  display fetch address, valid with disp_req.
REQ-007 logic_req  in  1  game-logic read request; level, held until grant.
REQ-008 logic_addr  in  ADDR_W  game-logic address; stable while logic_req=1.
REQ-009 rom_q  in  DATA_W  sprite ROM read data, 1-cycle read latency.
REQ-010 rom_address  out  ADDR_W  registered address to sprite ROM.
REQ-011 logic_gnt  out  1  1-cycle pulse; logic request accepted.
REQ-012 disp_valid  out  1  display data valid.
REQ-013 logic_valid  out  1  logic data valid.
REQ-014 rd_data  out  DATA_W  read data, qualified by disp_valid/logic_valid.
REQ-015 disp_miss  out  1  1-cycle pulse; a display request was dropped.
REQ-016 miss_count  out  16  saturating count of dropped display requests.

Function
REQ-017 Decision at each rising edge from sampled inputs: owner ∈ {NONE, DISP, LOGIC}, registered.
REQ-018 Effective logic request = logic_req AND NOT logic_gnt; no back-to-back logic grants.
REQ-019 blank=1: DISP wins over LOGIC, unless the starvation force is active (REQ-023).
REQ-020 blank=0: LOGIC wins over DISP.
REQ-021 Only one requester active: it wins. Neither active: owner=NONE, rom_address holds its previous value.
REQ-022 Cycle after decision (T+1): rom_address = winner address. logic_gnt=1 iff owner=LOGIC.
REQ-023 Starvation counter wait_cnt (8 bit):
  - increments each cycle the effective logic request is denied;
  - clears on a logic grant or when logic_req=0;
  - when wait_cnt = MAX_WAIT-1 and the effective request is still present, the next decision is forced to LOGIC regardless of blank.
REQ-024 Display request denied in any cycle: disp_miss pulses at T+1, and miss_count increments (saturates at 16'hFFFF, no wrap).
REQ-025 Owner tag travels a 2-stage pipeline alongside the address. At T+2: rd_data = rom_q, and disp_valid/logic_valid assert per tag. Total latency request->data is exactly 2 cycles.
REQ-026 disp_valid and logic_valid are never both 1. Both are 0 when tag=NONE.
REQ-027 Throughput: one grant per cycle. Back-to-back display grants are permitted indefinitely, subject to REQ-023.
REQ-028 logic_req withdrawn before grant: no grant is issued, and wait_cnt clears.
REQ-029 blank toggling mid-pipeline does not affect data already in flight.

Reset
REQ-030 While Reset=1 at an edge: rom_address=0, logic_gnt=0, disp_valid=0, logic_valid=0, rd_data=0, disp_miss=0, miss_count=0, wait_cnt=0, both tag stages=NONE.
REQ-031 Reset mid-operation discards in-flight reads. No valid asserts for requests sampled before or during reset.
REQ-032 First decision is made at the first edge with Reset=0. Its grant appears one cycle later.

Verification
REQ-033 blank=1, disp_req every cycle with disp_addr=n: rom_address=n at T+1, disp_valid=1 with rd_data=ROM[n] at T+2, every cycle, with no miss.
REQ-034 blank=0, disp_req and logic_req (addr 0x1234) together:
  - logic_gnt=1 at T+1 with rom_address=0x1234;
  - logic_valid=1 at T+2;
  - disp_miss=1 at T+1, miss_count=1.
REQ-035 blank=1, continuous disp_req, logic_req held, MAX_WAIT=16:
  - logic_gnt asserts exactly 17 cycles after logic_req first sampled;
  - that cycle's display request is dropped (disp_miss=1).
REQ-036 logic_req held high for 3 cycles in blanking: logic_gnt pulses once only and is not repeated the next cycle.
REQ-037 Reset asserted one cycle after a grant: no disp_valid or logic_valid for that request, and all outputs are 0 the cycle after the reset edge.
REQ-038 Force miss_count to 16'hFFFE, then drop 3 display requests: miss_count reads 16'hFFFF and stays there.
